// File: rtl/aes_job_arbiter.sv
// ---------------------------------------------------------------------------
// AesJobArbiter: shares one AES encrypt/decrypt core between two requesters.
// The requesters are the host-to-SD write path (encrypt) and the SD-to-host
// read path (decrypt).
//
// Each accepted 128-bit job is latched and issued to the core with a
// one-cycle enable pulse. The arbiter then waits for the core's completion
// pulse and captures the registered core output one cycle later. The result
// is held until the owning requester consumes it.
//
// Contention is resolved round-robin. Key updates are shadowed and applied
// only while idle. A watchdog aborts jobs the core never completes.
//
// Ports:
//   clk, n_rst             clock, asynchronous active-low reset
//   i_enc_valid/i_enc_data encrypt job request (held until accepted)
//   o_enc_ready            encrypt job accepted (1-cycle pulse)
//   i_dec_valid/i_dec_data decrypt job request (held until accepted)
//   o_dec_ready            decrypt job accepted (1-cycle pulse)
//   o_res_valid            result available, held until i_res_ready
//   o_res_is_enc           result owner: 1 = encrypt path, 0 = decrypt path
//   o_res_data             result block (0 when aborted)
//   o_res_err              result aborted by watchdog timeout
//   i_res_ready            owner consumes the result
//   i_key_load/i_key_value key update strobe and new key
//   o_key_pending          key update latched but not yet applied
//   o_busy                 high in every state except IDLE
//   o_aes_enable           1-cycle start pulse to the core
//   o_aes_enc_req          encrypt mode request to the core
//   o_aes_dec_req          decrypt mode request to the core
//   o_aes_key              key to the core
//   o_aes_data_in          job data to the core
//   i_aes_data_out         core result, valid one cycle after i_aes_data_ready
//   i_aes_data_ready       core completion pulse
// ---------------------------------------------------------------------------
module aes_job_arbiter #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic         clk,
    input  logic         n_rst,

    input  logic         i_enc_valid,
    input  logic [127:0] i_enc_data,
    output logic         o_enc_ready,

    input  logic         i_dec_valid,
    input  logic [127:0] i_dec_data,
    output logic         o_dec_ready,

    output logic         o_res_valid,
    output logic         o_res_is_enc,
    output logic [127:0] o_res_data,
    output logic         o_res_err,
    input  logic         i_res_ready,

    input  logic         i_key_load,
    input  logic [127:0] i_key_value,
    output logic         o_key_pending,

    output logic         o_busy,

    output logic         o_aes_enable,
    output logic         o_aes_enc_req,
    output logic         o_aes_dec_req,
    output logic [127:0] o_aes_key,
    output logic [127:0] o_aes_data_in,
    input  logic [127:0] i_aes_data_out,
    input  logic         i_aes_data_ready
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    state_t         r_state;
    logic [CNT_W-1:0] r_cnt;
    logic           r_rr_enc;
    logic           r_owner;

    logic           r_enc_ready;
    logic           r_dec_ready;
    logic           r_res_valid;
    logic           r_res_is_enc;
    logic [127:0]   r_res_data;
    logic           r_res_err;
    logic           r_busy;
    logic           r_aes_enable;
    logic           r_aes_enc_req;
    logic           r_aes_dec_req;
    logic [127:0]   r_aes_data_in;

    logic [127:0]   r_aes_key;
    logic [127:0]   r_key_shadow;
    logic           r_key_pending;

    logic           w_key_apply;
    logic           w_any_valid;
    logic           w_grant_enc;
    logic [CNT_W-1:0] w_cnt_next;
    logic           w_timeout;

    // A pending key is applied in IDLE ahead of any grant, so the core never
    // sees a key change while a job is in flight.
    assign w_key_apply = (r_state == ST_IDLE) && r_key_pending;

    // Encrypt wins when it is the only requester, or when both request and
    // the round-robin pointer currently favours encrypt.
    assign w_any_valid = i_enc_valid || i_dec_valid;
    assign w_grant_enc = i_enc_valid && (!i_dec_valid || r_rr_enc);

    // The watchdog fires on the WAIT cycle that would bring the count to
    // TIMEOUT_CYC, giving exactly TIMEOUT_CYC WAIT cycles per job.
    assign w_cnt_next  = r_cnt + CNT_W'(1);
    assign w_timeout   = (w_cnt_next == CNT_W'(TIMEOUT_CYC));

    // Key shadow register. A load in the same cycle as an apply is written
    // last, so the newer value stays pending for the next IDLE visit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_key_shadow  <= '0;
            r_key_pending <= 1'b0;
            r_aes_key     <= '0;
        end else begin
            if (w_key_apply) begin
                r_aes_key     <= r_key_shadow;
                r_key_pending <= 1'b0;
            end
            if (i_key_load) begin
                r_key_shadow  <= i_key_value;
                r_key_pending <= 1'b1;
            end
        end
    end

    // Job sequencer. All externally visible controls are registered here;
    // the ready and enable pulses default low and are raised only on the
    // transition that owns them.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_rr_enc      <= 1'b1;
            r_owner       <= 1'b0;
            r_enc_ready   <= 1'b0;
            r_dec_ready   <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_is_enc  <= 1'b0;
            r_res_data    <= '0;
            r_res_err     <= 1'b0;
            r_busy        <= 1'b0;
            r_aes_enable  <= 1'b0;
            r_aes_enc_req <= 1'b0;
            r_aes_dec_req <= 1'b0;
            r_aes_data_in <= '0;
        end else begin
            r_enc_ready  <= 1'b0;
            r_dec_ready  <= 1'b0;
            r_aes_enable <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (!w_key_apply && w_any_valid) begin
                        r_owner       <= w_grant_enc;
                        r_enc_ready   <= w_grant_enc;
                        r_dec_ready   <= !w_grant_enc;
                        r_aes_data_in <= w_grant_enc ? i_enc_data : i_dec_data;
                        // The pointer only moves when there was a contest.
                        if (i_enc_valid && i_dec_valid) begin
                            r_rr_enc <= !r_rr_enc;
                        end
                        r_aes_enable  <= 1'b1;
                        r_aes_enc_req <= w_grant_enc;
                        r_aes_dec_req <= !w_grant_enc;
                        r_busy        <= 1'b1;
                        r_state       <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    r_cnt <= w_cnt_next;
                    // A completion in the final watchdog cycle still wins.
                    if (i_aes_data_ready) begin
                        r_state <= ST_CAPTURE;
                    end else if (w_timeout) begin
                        r_res_valid   <= 1'b1;
                        r_res_is_enc  <= r_owner;
                        r_res_data    <= '0;
                        r_res_err     <= 1'b1;
                        r_aes_enc_req <= 1'b0;
                        r_aes_dec_req <= 1'b0;
                        r_state       <= ST_RESP;
                    end
                end

                ST_CAPTURE: begin
                    // The core registers its output, so the block is valid
                    // the cycle after the completion pulse.
                    r_res_valid   <= 1'b1;
                    r_res_is_enc  <= r_owner;
                    r_res_data    <= i_aes_data_out;
                    r_res_err     <= 1'b0;
                    r_aes_enc_req <= 1'b0;
                    r_aes_dec_req <= 1'b0;
                    r_state       <= ST_RESP;
                end

                ST_RESP: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_enc_ready   = r_enc_ready;
    assign o_dec_ready   = r_dec_ready;
    assign o_res_valid   = r_res_valid;
    assign o_res_is_enc  = r_res_is_enc;
    assign o_res_data    = r_res_data;
    assign o_res_err     = r_res_err;
    assign o_key_pending = r_key_pending;
    assign o_busy        = r_busy;
    assign o_aes_enable  = r_aes_enable;
    assign o_aes_enc_req = r_aes_enc_req;
    assign o_aes_dec_req = r_aes_dec_req;
    assign o_aes_key     = r_aes_key;
    assign o_aes_data_in = r_aes_data_in;

endmodule

// File: tb/tb_aes_job_arbiter.sv
// ---------------------------------------------------------------------------
// TbAesJobArbiter: self-checking bench for aes_job_arbiter.
//
// A small behavioural core answers each enable pulse after a programmable
// delay, or never when it is told to hang. Expected grants and results are
// queued by the test sequence and compared by a monitor as the DUT produces
// them.
// ---------------------------------------------------------------------------
module tb_aes_job_arbiter;

    localparam logic [127:0] KEY1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEYFF = {128{1'b1}};
    localparam logic [127:0] KEY11 = {16{8'h11}};
    localparam logic [127:0] JUNK  = 128'hdeadbeef_cafef00d_0badc0de_feedface;

    logic         clk = 1'b0;
    logic         nRst;
    logic         encValid, decValid, encReady, decReady;
    logic [127:0] encData, decData;
    logic         resValid, resIsEnc, resErr, resReady;
    logic [127:0] resData;
    logic         keyLoad, keyPending, busy;
    logic [127:0] keyValue;
    logic         aesEnable, aesEncReq, aesDecReq, aesDataReady;
    logic [127:0] aesKey, aesDataIn, aesDataOut;

    typedef struct {
        logic         isEnc;
        logic [127:0] data;
        logic         err;
    } result_t;

    result_t expResQ[$];
    logic    expGrantQ[$];

    int           checkCount   = 0;
    int           errorCount   = 0;
    int           outstanding  = 0;
    int           cycleNum     = 0;
    int           enableCount  = 0;
    int           enableCycle  = 0;
    int           lastResCycle = 0;
    int           coreDelay    = 1;
    logic         coreHang     = 1'b0;
    logic         lastReqEnc   = 1'b0;
    logic         lastReqDec   = 1'b0;
    logic [127:0] lastKey      = '0;
    logic [127:0] curKey       = '0;
    logic [127:0] expA;
    logic         monExpG;
    result_t      monExpR;
    int           enBefore;

    aes_job_arbiter #(
        .TIMEOUT_CYC (64),
        .CNT_W       (7)
    ) dut (
        .clk              (clk),
        .n_rst            (nRst),
        .i_enc_valid      (encValid),
        .i_enc_data       (encData),
        .o_enc_ready      (encReady),
        .i_dec_valid      (decValid),
        .i_dec_data       (decData),
        .o_dec_ready      (decReady),
        .o_res_valid      (resValid),
        .o_res_is_enc     (resIsEnc),
        .o_res_data       (resData),
        .o_res_err        (resErr),
        .i_res_ready      (resReady),
        .i_key_load       (keyLoad),
        .i_key_value      (keyValue),
        .o_key_pending    (keyPending),
        .o_busy           (busy),
        .o_aes_enable     (aesEnable),
        .o_aes_enc_req    (aesEncReq),
        .o_aes_dec_req    (aesDecReq),
        .o_aes_key        (aesKey),
        .o_aes_data_in    (aesDataIn),
        .i_aes_data_out   (aesDataOut),
        .i_aes_data_ready (aesDataReady)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleNum++;

    // Stand-in for the AES core: the known test vector for the real key,
    // otherwise a keyed scramble that still depends on mode, data and key.
    function automatic logic [127:0] coreFn(input logic isEnc, input logic [127:0] d,
                                            input logic [127:0] k);
        if (isEnc && d == PT1 && k == KEY1) return CT1;
        if (isEnc) return {d[63:0], d[127:64]} ^ k ^ {32{4'ha}};
        return d ^ {k[63:0], k[127:64]} ^ {32{4'h3}};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic expectJob(input logic isEnc, input logic [127:0] data,
                             input logic timeoutErr, input logic [127:0] key);
        result_t r;
        r.isEnc = isEnc;
        r.err   = timeoutErr;
        r.data  = timeoutErr ? '0 : coreFn(isEnc, data, key);
        expGrantQ.push_back(isEnc);
        expResQ.push_back(r);
    endtask

    // Requester: raise valid now, hold until the matching ready is seen,
    // then drop valid just after the next rising edge.
    task automatic applyStimulus(input logic isEnc, input logic [127:0] data);
        bit accepted = 1'b0;
        if (isEnc) begin encData = data; encValid = 1'b1; end
        else       begin decData = data; decValid = 1'b1; end
        for (int i = 0; i < 400 && !accepted; i++) begin
            @(negedge clk);
            accepted = isEnc ? encReady : decReady;
        end
        if (!accepted) checkOutput(isEnc ? "encAcceptTimeout" : "decAcceptTimeout", 128'd0, 128'd1);
        @(posedge clk); #1;
        if (isEnc) encValid = 1'b0;
        else       decValid = 1'b0;
    endtask

    task automatic applyKey(input logic [127:0] k);
        keyLoad  = 1'b1;
        keyValue = k;
        @(posedge clk); #1;
        keyLoad  = 1'b0;
    endtask

    task automatic waitResValid(input int maxCycles);
        bit seen = 1'b0;
        for (int i = 0; i < maxCycles && !seen; i++) begin
            @(negedge clk);
            seen = resValid;
        end
        if (!seen) checkOutput("resValidTimeout", 128'd0, 128'd1);
    endtask

    task automatic waitDrain(input int maxCycles);
        bit done = 1'b0;
        for (int i = 0; i < maxCycles && !done; i++) begin
            @(negedge clk);
            done = (expResQ.size() == 0) && (expGrantQ.size() == 0) && !busy;
        end
        if (!done) checkOutput("drainTimeout", 128'd0, 128'd1);
        @(posedge clk); #1;
    endtask

    // Behavioural core: answers each enable after coreDelay cycles with a
    // one-cycle ready pulse, result on the following cycle, junk otherwise.
    initial begin
        aesDataReady = 1'b0;
        aesDataOut   = JUNK;
        forever begin
            @(negedge clk);
            if (nRst && aesEnable) begin
                logic [127:0] res;
                lastReqEnc  = aesEncReq;
                lastReqDec  = aesDecReq;
                lastKey     = aesKey;
                enableCycle = cycleNum;
                if (!coreHang) begin
                    res = coreFn(aesEncReq, aesDataIn, aesKey);
                    repeat (coreDelay) @(posedge clk);
                    #1 aesDataReady = 1'b1;
                    @(posedge clk);
                    #1 aesDataReady = 1'b0;
                    aesDataOut = res;
                    @(posedge clk);
                    #1 aesDataOut = JUNK;
                end
            end
        end
    end

    // Scoreboard monitor: grants are checked against the predicted order and
    // for single-job occupancy; consumed results against the expected queue.
    always @(negedge clk) begin
        if (!nRst) begin
            outstanding = 0;
        end else begin
            if (aesEnable) enableCount++;
            if (encReady || decReady) begin
                checkOutput("readyExclusive", 128'(encReady && decReady), 128'd0);
                checkOutput("oneOutstanding", 128'(outstanding), 128'd0);
                if (expGrantQ.size() == 0) begin
                    checkOutput("unexpectedGrant", 128'd1, 128'd0);
                end else begin
                    monExpG = expGrantQ.pop_front();
                    checkOutput("grantSide", 128'(encReady), 128'(monExpG));
                end
                outstanding++;
            end
            if (resValid && resReady) begin
                lastResCycle = cycleNum;
                if (expResQ.size() == 0) begin
                    checkOutput("unexpectedResult", 128'd1, 128'd0);
                end else begin
                    monExpR = expResQ.pop_front();
                    checkOutput("resIsEnc", 128'(resIsEnc), 128'(monExpR.isEnc));
                    checkOutput("resData", resData, monExpR.data);
                    checkOutput("resErr", 128'(resErr), 128'(monExpR.err));
                end
                if (outstanding > 0) outstanding--;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL globalTimeout: observed no finish, expected finish");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        nRst     = 1'b0;
        encValid = 1'b0; decValid = 1'b0;
        encData  = '0;   decData  = '0;
        resReady = 1'b1;
        keyLoad  = 1'b0; keyValue = '0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rstCtrl", 128'({encReady, decReady, resValid, resIsEnc, resErr,
                                     keyPending, busy, aesEnable, aesEncReq, aesDecReq}), 128'd0);
        checkOutput("rstResData", resData, 128'd0);
        checkOutput("rstKey", aesKey, 128'd0);
        checkOutput("rstDataIn", aesDataIn, 128'd0);
        @(posedge clk); #1;
        nRst = 1'b1;
        @(posedge clk); #1;

        // Single encrypt with key applied before the grant
        $display("[TB] single encrypt");
        coreDelay = 20;
        enBefore  = enableCount;
        expectJob(1'b1, PT1, 1'b0, KEY1);
        applyKey(KEY1);
        fork
            applyStimulus(1'b1, PT1);
            begin
                @(negedge clk);
                checkOutput("keyPendingBeforeApply", 128'(keyPending), 128'd1);
                checkOutput("keyNotYetApplied", aesKey, 128'd0);
                @(negedge clk);
                checkOutput("keyApplied", aesKey, KEY1);
                checkOutput("keyPendingCleared", 128'(keyPending), 128'd0);
                checkOutput("noGrantInApplyCycle", 128'(encReady), 128'd0);
            end
        join
        curKey = KEY1;
        waitDrain(200);
        checkOutput("t1EnableCount", 128'(enableCount - enBefore), 128'd1);
        checkOutput("t1EncReq", 128'(lastReqEnc), 128'd1);
        checkOutput("t1DecReq", 128'(lastReqDec), 128'd0);
        checkOutput("t1CoreKey", lastKey, KEY1);
        checkOutput("t1Latency", 128'(lastResCycle - enableCycle), 128'd22);

        // Simultaneous requests alternate enc, dec, enc, dec
        $display("[TB] simultaneous requests");
        coreDelay = 3;
        expectJob(1'b1, 128'h1001, 1'b0, curKey);
        expectJob(1'b0, 128'h2001, 1'b0, curKey);
        expectJob(1'b1, 128'h1002, 1'b0, curKey);
        expectJob(1'b0, 128'h2002, 1'b0, curKey);
        fork
            begin applyStimulus(1'b1, 128'h1001); applyStimulus(1'b1, 128'h1002); end
            begin applyStimulus(1'b0, 128'h2001); applyStimulus(1'b0, 128'h2002); end
        join
        waitDrain(200);

        // Backpressure: result held, queued request waits for release
        $display("[TB] backpressure");
        coreDelay = 2;
        resReady  = 1'b0;
        expA = coreFn(1'b1, 128'h3333, curKey);
        expectJob(1'b1, 128'h3333, 1'b0, curKey);
        expectJob(1'b0, 128'h4444, 1'b0, curKey);
        applyStimulus(1'b1, 128'h3333);
        fork
            applyStimulus(1'b0, 128'h4444);
        join_none
        waitResValid(50);
        repeat (10) begin
            checkOutput("bpValid", 128'(resValid), 128'd1);
            checkOutput("bpData", resData, expA);
            checkOutput("bpNoGrant", 128'(encReady || decReady), 128'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        resReady = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bpValidDropped", 128'(resValid), 128'd0);
        checkOutput("bpIdle", 128'(busy), 128'd0);
        checkOutput("bpNoGrantYet", 128'(decReady), 128'd0);
        @(negedge clk);
        checkOutput("bpGrantNext", 128'(decReady), 128'd1);
        @(posedge clk); #1;
        waitDrain(200);

        // Watchdog timeout, then a normal job
        $display("[TB] timeout");
        coreHang = 1'b1;
        expectJob(1'b1, 128'h5555, 1'b1, curKey);
        applyStimulus(1'b1, 128'h5555);
        waitResValid(120);
        checkOutput("toErr", 128'(resErr), 128'd1);
        checkOutput("toData", resData, 128'd0);
        checkOutput("toLatency", 128'(cycleNum - enableCycle), 128'd65);
        @(posedge clk); #1;
        coreHang  = 1'b0;
        coreDelay = 5;
        expectJob(1'b0, 128'h6666, 1'b0, curKey);
        applyStimulus(1'b0, 128'h6666);
        waitResValid(50);
        checkOutput("afterToLatency", 128'(cycleNum - enableCycle), 128'd7);
        checkOutput("afterToErr", 128'(resErr), 128'd0);
        @(posedge clk); #1;
        waitDrain(100);

        // Key updates during WAIT are deferred to IDLE; last load wins
        $display("[TB] key deferral");
        coreDelay = 30;
        expectJob(1'b1, 128'h7777, 1'b0, curKey);
        expectJob(1'b0, 128'h8888, 1'b0, KEY11);
        applyStimulus(1'b1, 128'h7777);
        repeat (4) @(posedge clk);
        #1;
        applyKey(KEYFF);
        @(negedge clk);
        checkOutput("kdKeyHeld", aesKey, KEY1);
        checkOutput("kdPending", 128'(keyPending), 128'd1);
        repeat (3) @(posedge clk);
        #1;
        applyKey(KEY11);
        fork
            applyStimulus(1'b0, 128'h8888);
        join_none
        waitResValid(60);
        checkOutput("kdKeyInResp", aesKey, KEY1);
        @(negedge clk);
        checkOutput("kdKeyInIdle", aesKey, KEY1);
        checkOutput("kdPendingInIdle", 128'(keyPending), 128'd1);
        @(negedge clk);
        checkOutput("kdKeyApplied", aesKey, KEY11);
        checkOutput("kdPendingCleared", 128'(keyPending), 128'd0);
        checkOutput("kdNoGrantInApply", 128'(decReady), 128'd0);
        @(negedge clk);
        checkOutput("kdGrantNext", 128'(decReady), 128'd1);
        @(posedge clk); #1;
        waitDrain(200);

        // Reset during WAIT discards the job and re-arms encrypt-first
        $display("[TB] reset mid-wait");
        coreHang = 1'b1;
        expGrantQ.push_back(1'b1);
        applyStimulus(1'b1, 128'h9999);
        repeat (3) @(posedge clk);
        #1;
        nRst = 1'b0;
        #1;
        checkOutput("midRstCtrl", 128'({encReady, decReady, resValid, resIsEnc, resErr,
                                        keyPending, busy, aesEnable, aesEncReq, aesDecReq}), 128'd0);
        checkOutput("midRstResData", resData, 128'd0);
        checkOutput("midRstKey", aesKey, 128'd0);
        checkOutput("midRstDataIn", aesDataIn, 128'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        nRst      = 1'b1;
        coreHang  = 1'b0;
        coreDelay = 4;
        curKey    = '0;
        expectJob(1'b1, 128'haaaa, 1'b0, curKey);
        expectJob(1'b0, 128'hbbbb, 1'b0, curKey);
        fork
            applyStimulus(1'b1, 128'haaaa);
            applyStimulus(1'b0, 128'hbbbb);
        join
        waitDrain(200);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/aes_job_arbiter.md
Name: aes_job_arbiter

Overview:
- Sequences and shares the single AES encrypt/decrypt core between two requesters.
  - Encrypt requester: the host-to-SD write path.
  - Decrypt requester: the SD-to-host read path.
- Latches each 128-bit job and drives the core's request/enable inputs. Waits for data_ready, captures the registered core output and returns it to the requester that owns the job.
- Round-robin arbitration, a key-load port with deferred apply, and a watchdog timeout.

Parameters:
- TIMEOUT_CYC, 64, max cycles spent in WAIT before a job is aborted (≥ 24).
- CNT_W, 7, width of the watchdog counter (must hold TIMEOUT_CYC).

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- enc_valid  in  1  encrypt job request (level, held until accepted)
- enc_data  in  128  plaintext block
- enc_ready  out  1  encrypt job accepted this cycle (1-cycle pulse)
- dec_valid  in  1  decrypt job request
- dec_data  in  128  ciphertext block
- dec_ready  out  1  decrypt job accepted this cycle (1-cycle pulse)
- res_valid  out  1  result available
- res_is_enc  out  1  result owner: 1 = encrypt path, 0 = decrypt path
- res_data  out  128  result block
- res_err  out  1  result aborted by timeout (res_data = 0)
- res_ready  in  1  owner consumes result
- key_load  in  1  1-cycle key update strobe
- key_value  in  128  new key
- key_pending  out  1  key update latched but not yet applied
- busy  out  1  high in every state except IDLE
- aes_enable  out  1  1-cycle start pulse to core
- aes_enc_req  out  1  encrypt mode request to core
- aes_dec_req  out  1  decrypt mode request to core
- aes_key  out  128  key to core
- aes_data_in  out  128  job data to core
- aes_data_out  in  128  core result, registered one cycle after aes_data_ready
- aes_data_ready  in  1  core completion pulse

Behaviour:
- Reset values:
  - All outputs 0; aes_key = 0.
  - Round-robin pointer = encrypt-first.
  - State IDLE, watchdog counter 0.
- Reset mid-job: the job is discarded, nothing is reported, the core is released.
- States: IDLE, ISSUE, WAIT, CAPTURE, RESP.
- IDLE:
  - If a key update is pending, apply it first: aes_key <= shadow, clear key_pending. No grant in that cycle.
  - Otherwise, if enc_valid or dec_valid is high, grant:
    - Only one valid: grant it.
    - Both valid: grant the side named by the pointer, then flip the pointer to the other side.
  - On grant, pulse the matching *_ready and latch the data into aes_data_in.
  - Set the owner bit and go to ISSUE.
- ISSUE (1 cycle):
  - aes_enable = 1.
  - aes_enc_req = owner, aes_dec_req = !owner. Both are held through ISSUE, WAIT and CAPTURE and are 0 elsewhere.
  - Clear the watchdog and go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - aes_data_ready = 1 → CAPTURE.
  - Counter reaches TIMEOUT_CYC with no ready → RESP with res_err = 1, res_data = 0.
  - If ready and timeout coincide, ready wins.
- CAPTURE (1 cycle): res_data <= aes_data_out, res_err = 0, go to RESP.
- RESP:
  - res_valid = 1; res_is_enc, res_data and res_err are stable.
  - Hold until res_ready. In the res_ready cycle go to IDLE; res_valid drops the next cycle.
  - No new grant is made in the RESP→IDLE transition cycle.
- Latency: grant to res_valid = 3 + (cycles in WAIT, ≥ 1) cycles. Minimum 4 when core ready arrives the first WAIT cycle.
- aes_data_ready outside WAIT is ignored.
- key_load:
  - Always latched into the shadow register and sets key_pending.
  - A second key_load before apply overwrites the shadow; the last value wins.
  - key_load in the same cycle as apply: the new value stays pending.
- Accepted job data, owner and aes_key are stable from ISSUE through RESP.
- Requesters may drop *_valid without acceptance; no state effect.

Test Plan:
- Single encrypt:
  - Stimulus: key_load key=000102..0f, then enc_valid data=00112233445566778899aabbccddeeff. Core model returns 69c4e0d86a7b0430d8cdb78070b4c55a after 20 cycles.
  - Required response: aes_key applied before grant; one enable pulse with aes_enc_req=1; res_valid, res_is_enc=1, res_data=69c4e0d8..., res_err=0.
- Simultaneous requests:
  - Stimulus: enc_valid and dec_valid both held for 4 jobs.
  - Required response: grant order enc, dec, enc, dec; each res_is_enc matches; never two jobs outstanding.
- Backpressure:
  - Stimulus: hold res_ready=0 for 10 cycles.
  - Required response: res_valid/res_data stable; no *_ready pulses; release → IDLE, next grant one cycle later.
- Timeout:
  - Stimulus: core never asserts aes_data_ready.
  - Required response: after 64 WAIT cycles, res_valid=1, res_err=1, res_data=0; subsequent job completes normally.
- Key deferral:
  - Stimulus: key_load mid-WAIT with key=ff..ff, then a second load key=11..11 before job end.
  - Required response: aes_key unchanged until IDLE; then aes_key=11..11 with key_pending cleared; the queued request is granted the next cycle.
- Reset mid-WAIT:
  - Stimulus: assert n_rst low during WAIT.
  - Required response: all outputs 0 immediately; no res_valid after release; the first grant after reset goes to encrypt.
